whack_game_core: RTL

Parametrised target-and-hit game engine for the board-level whack-a-LED games. It takes decoded key hits from the keyboard front end and drives the target LEDs and the time/score values for the 7-segment controller. It owns the round state machine, a game-tick divider, a countdown timer, a score counter, an LFSR target generator and a flashing result phase. Compared with the previous single-purpose game logic, it adds a configurable target count, LFSR width and taps, tick period and seed, plus an optional miss-penalty mode.

---
 rtl/whack_game_core.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/whack_game_core.sv
// whack_game_core
// Round engine for the whack-a-LED games: takes decoded key hits and drives
// the target LEDs plus the time/score values shown on the 7-segment display.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   start        one-cycle start pulse (starts a round from IDLE, restarts in PLAY)
//   cfg_time     round length in ticks, latched on start
//   cfg_goal     hits needed to win (0 behaves as 1), latched on start
//   cfg_seed     LFSR seed (0 behaves as 1), latched on start
//   cfg_penalty  1 = a miss costs one point, latched on start
//   hit_valid    one-cycle key press pulse
//   hit_idx      target index of the key press (may be out of range)
//   targets      target LED pattern
//   time_left    remaining ticks in the round
//   score        current score
//   state        0 = IDLE, 1 = PLAY, 2 = RESULT (debug/observability)
//   done         high throughout RESULT
//   win          round outcome, valid while done is high
//
// Handshake: start and hit_valid are single-cycle pulses with no ready;
// every pulse sampled high on a clock edge is acted on in that cycle.
module whack_game_core #(
  parameter int                N_TARGETS    = 16,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400,
  parameter int                TICK_DIV     = 100_000_000,
  parameter int                TIME_W       = 8,
  parameter int                SCORE_W      = 8,
  parameter int                RESULT_TICKS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [TIME_W-1:0]            cfg_time,
  input  logic [SCORE_W-1:0]           cfg_goal,
  input  logic [LFSR_W-1:0]            cfg_seed,
  input  logic                         cfg_penalty,
  input  logic                         hit_valid,
  input  logic [$clog2(N_TARGETS):0]   hit_idx,
  output logic [N_TARGETS-1:0]         targets,
  output logic [TIME_W-1:0]            time_left,
  output logic [SCORE_W-1:0]           score,
  output logic [1:0]                   state,
  output logic                         done,
  output logic                         win
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RT_W  = $clog2(RESULT_TICKS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [RT_W-1:0]      rcnt_q;
  logic [LFSR_W-1:0]    lfsr_q;
  logic [SCORE_W-1:0]   goal_q;
  logic                 penalty_q;

  logic                 tick;
  logic                 round_over;
  logic                 round_won;
  logic                 load_round;
  logic                 enter_result;
  logic                 result_last;
  logic [LFSR_W-1:0]    lfsr_next;
  logic [LFSR_W-1:0]    seed_eff;
  logic [SCORE_W-1:0]   goal_eff;
  logic [N_TARGETS-1:0] idx_mask;
  logic                 hit_lit;

  // One-hot of the pressed index; an out-of-range index shifts out to zero,
  // so it can never match a lit target.
  assign idx_mask = N_TARGETS'(1) << hit_idx;
  assign hit_lit  = hit_valid && (|(targets & idx_mask));

  assign tick = ((state_q == S_PLAY) || (state_q == S_RESULT)) &&
                (cnt_q == CNT_W'(TICK_DIV - 1));

  // End of round is judged on registered score/time only.
  assign round_won    = (score >= goal_q);
  assign round_over   = round_won || (time_left == '0);
  assign load_round   = start && ((state_q == S_IDLE) || (state_q == S_PLAY));
  assign enter_result = (state_q == S_PLAY) && !start && round_over;
  assign result_last  = tick && (rcnt_q == RT_W'(RESULT_TICKS - 1));

  // Galois step: shift right, fold the taps back in when bit 0 falls out.
  assign lfsr_next = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  assign seed_eff  = (cfg_seed == '0) ? LFSR_W'(1) : cfg_seed;
  assign goal_eff  = (cfg_goal == '0) ? SCORE_W'(1) : cfg_goal;

  // ---------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_PLAY;
      S_PLAY:   if (!start && round_over) state_d = S_RESULT;
      S_RESULT: if (result_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    state = state_q;
    done  = (state_q == S_RESULT);
  end

  // ---------------------------------------------------------------------
  // Tick divider: free-running only in PLAY/RESULT, restarted on every
  // phase entry so each phase sees whole ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_round || enter_result ||
                 ((state_q != S_PLAY) && (state_q != S_RESULT))) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Ticks spent in RESULT.
  always_ff @(posedge clk) begin
    if (rst || (state_q != S_RESULT)) rcnt_q <= '0;
    else if (tick)                    rcnt_q <= rcnt_q + RT_W'(1);
  end

  // ---------------------------------------------------------------------
  // Round datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      targets   <= '0;
      time_left <= '0;
      score     <= '0;
      win       <= 1'b0;
      lfsr_q    <= '0;
      goal_q    <= '0;
      penalty_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_PLAY: begin
          if (start) begin
            score     <= '0;
            time_left <= cfg_time;
            lfsr_q    <= seed_eff;
            targets   <= seed_eff[N_TARGETS-1:0];
            goal_q    <= goal_eff;
            penalty_q <= cfg_penalty;
          end else if (state_q == S_IDLE) begin
            targets <= '0;
          end else begin
            if (hit_lit) begin
              if (score != '1) score <= score + SCORE_W'(1);
            end else if (hit_valid && penalty_q) begin
              if (score != '0) score <= score - SCORE_W'(1);
            end

            if (tick) begin
              lfsr_q <= lfsr_next;
              if (time_left != '0) time_left <= time_left - TIME_W'(1);
            end

            // Priority for the LED pattern: result flash, then the tick
            // reload (which swallows a same-cycle clear), then the clear.
            if (round_over) begin
              win     <= round_won;
              targets <= '1;
            end else if (tick) begin
              targets <= lfsr_next[N_TARGETS-1:0];
            end else if (hit_lit) begin
              targets <= targets & ~idx_mask;
            end
          end
        end
        S_RESULT: begin
          if (result_last) targets <= '0;
          else if (tick)   targets <= ~targets;
        end
        default: targets <= '0;
      endcase
    end
  end

endmodule
